// File: rtl/sfp_pkg.sv
// Shared definitions for the signed fixed-point (SFP) math library:
// default Q16.16 format, the sfp_t scalar type, range limits and the
// state encoding used by the sequential vector divider.
package sfp_pkg;

  localparam int SFP_WIDTH = 32;
  localparam int SFP_FRAC  = 16;

  typedef logic signed [SFP_WIDTH-1:0] sfp_t;

  localparam sfp_t SFP_MAX = sfp_t'({1'b0, {(SFP_WIDTH-1){1'b1}}});
  localparam sfp_t SFP_MIN = sfp_t'({1'b1, {(SFP_WIDTH-1){1'b0}}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/sfp_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
// RW must be wide enough that {rem, dvd_bit} never overflows, which holds
// when rem < divisor and RW is one bit wider than the divisor magnitude.
module sfp_div_step #(
  parameter int RW = 33
) (
  input  logic [RW-1:0] rem,
  input  logic [RW-1:0] divisor,
  input  logic          dvd_bit,
  output logic [RW-1:0] rem_next,
  output logic          q_bit
);

  logic [RW:0] trial;
  logic [RW:0] diff;

  // trial subtract; keep the difference only when the divisor fits
  always_comb begin
    trial    = {rem, dvd_bit};
    diff     = trial - {1'b0, divisor};
    q_bit    = (trial >= {1'b0, divisor});
    rem_next = q_bit ? diff[RW-1:0] : trial[RW-1:0];
  end

endmodule

// File: rtl/sfp_vec_div_s.sv
// Sequential vector-by-scalar SFP divider: out[i] = a[i] / s.
// One restoring datapath is time-shared over the N components; each
// component takes WIDTH+FRAC divide cycles plus one fix-up cycle, and the
// result vector is published one cycle after the last fix-up.
// Optional macro SFP_VEC_DIV_FLAGS_EN adds the clipping[] and div_by_zero
// status outputs; arithmetic and timing do not depend on it.
module sfp_vec_div_s
  import sfp_pkg::*;
#(
  parameter int N     = 3,
  parameter bit CLIP  = 1'b1,
  parameter int WIDTH = SFP_WIDTH,
  parameter int FRAC  = SFP_FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0][WIDTH-1:0] a,
  input  logic [WIDTH-1:0]        s,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0][WIDTH-1:0] out
`ifdef SFP_VEC_DIV_FLAGS_EN
  ,
  output logic [N-1:0]            clipping,
  output logic                    div_by_zero
`endif
);

  localparam int DW    = WIDTH + FRAC;            // dividend / quotient bits
  localparam int RW    = WIDTH + 1;               // partial remainder bits
  localparam int STEPS = DW;
  localparam int CW    = $clog2(STEPS);
  localparam int KW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [WIDTH-1:0] VMAX    = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] VMIN    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DW-1:0]    LIM_POS = DW'(VMAX);
  localparam logic [DW-1:0]    LIM_NEG = LIM_POS + DW'(1);

  div_state_e               state;
  logic [N-1:0][WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]         s_q;
  logic [KW-1:0]            k;
  logic [CW-1:0]            cnt;
  logic [DW-1:0]            dvd;
  logic [DW-1:0]            quo;
  logic [RW-1:0]            rem;

  logic [RW-1:0]            rem_next;
  logic                     q_bit;
  logic [WIDTH-1:0]         s_mag;
  logic [WIDTH-1:0]         a0_mag;
  logic [WIDTH-1:0]         an_mag;
  logic [KW-1:0]            k_nxt;

  logic [WIDTH-1:0]         a_cur;
  logic [WIDTH-1:0]         q_low;
  logic [WIDTH-1:0]         signed_res;
  logic                     neg;
  logic                     ovf;
  logic [WIDTH-1:0]         fix_val;
`ifdef SFP_VEC_DIV_FLAGS_EN
  logic                     fix_clip;
`endif

  sfp_div_step #(.RW(RW)) u_step (
    .rem      (rem),
    .divisor  ({1'b0, s_mag}),
    .dvd_bit  (dvd[DW-1]),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // operand magnitudes: divisor, first component (straight from the input
  // on accept) and the component that follows k (from the latched copy)
  always_comb begin
    k_nxt  = (k == KW'(N-1)) ? '0 : k + KW'(1);
    s_mag  = s_q[WIDTH-1] ? -s_q : s_q;
    a0_mag = a[0][WIDTH-1] ? -a[0] : a[0];
    an_mag = a_q[k_nxt][WIDTH-1] ? -a_q[k_nxt] : a_q[k_nxt];
  end

  // sign, range check and zero-divisor override for component k
  always_comb begin
    a_cur      = a_q[k];
    neg        = a_cur[WIDTH-1] ^ s_q[WIDTH-1];
    ovf        = neg ? (quo > LIM_NEG) : (quo > LIM_POS);
    q_low      = quo[WIDTH-1:0];
    signed_res = neg ? -q_low : q_low;
    fix_val    = signed_res;
`ifdef SFP_VEC_DIV_FLAGS_EN
    fix_clip   = 1'b0;
`endif
    if (s_q == '0) begin
      // quotient bits are meaningless here; report the signed limit
      if (a_cur == '0)          fix_val = '0;
      else if (a_cur[WIDTH-1])  fix_val = VMIN;
      else                      fix_val = VMAX;
`ifdef SFP_VEC_DIV_FLAGS_EN
      fix_clip = (a_cur != '0);
`endif
    end else if (ovf) begin
      if (CLIP) fix_val = neg ? VMIN : VMAX;
`ifdef SFP_VEC_DIV_FLAGS_EN
      fix_clip = 1'b1;
`endif
    end
  end

  // control FSM, shared divider registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      a_q       <= '0;
      s_q       <= '0;
      k         <= '0;
      cnt       <= '0;
      dvd       <= '0;
      quo       <= '0;
      rem       <= '0;
`ifdef SFP_VEC_DIV_FLAGS_EN
      clipping    <= '0;
      div_by_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            s_q      <= s;
            k        <= '0;
            cnt      <= '0;
            dvd      <= {a0_mag, {FRAC{1'b0}}};
            rem      <= '0;
            quo      <= '0;
            in_ready <= 1'b0;
`ifdef SFP_VEC_DIV_FLAGS_EN
            clipping    <= '0;
            div_by_zero <= 1'b0;
`endif
            state    <= DIV;
          end
        end
        DIV: begin
          dvd <= dvd << 1;
          rem <= rem_next;
          quo <= {quo[DW-2:0], q_bit};
          if (cnt == CW'(STEPS-1)) state <= FIX;
          else                     cnt   <= cnt + CW'(1);
        end
        FIX: begin
          out[k] <= fix_val;
`ifdef SFP_VEC_DIV_FLAGS_EN
          clipping[k] <= fix_clip;
`endif
          if (k == KW'(N-1)) begin
            state <= DONE;
          end else begin
            k     <= k_nxt;
            cnt   <= '0;
            dvd   <= {an_mag, {FRAC{1'b0}}};
            rem   <= '0;
            state <= DIV;
          end
        end
        DONE: begin
          // first DONE cycle publishes; later cycles wait for the consumer
          if (!out_valid) begin
            out_valid <= 1'b1;
`ifdef SFP_VEC_DIV_FLAGS_EN
            div_by_zero <= (s_q == '0);
`endif
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
